i2c_master_driver: RTL and testbench
====================================

Name: i2c_master_driver

Overview:
- Single-master I2C bus driver inside the I2C processing unit.
- On `start_transaction` it addresses the 7-bit slave `ADDRES_DEVICE` and moves one DATA_WIDTH word as DATA_WIDTH/I2C_DATA_WIDTH bytes, MSB byte first.
  - Write: bytes are fetched from the host through the `i2c_prepare` / `data_in` handshake.
  - Read: bytes are assembled into `data_out`.
- Pairs on the bus with the companion I2C slave driver.

Parameters:
- I2C_DATA_WIDTH, 8: bits per I2C byte.
- DATA_WIDTH, 32: word size per transaction; must be a multiple of I2C_DATA_WIDTH. BYTES = DATA_WIDTH/I2C_DATA_WIDTH.
- ADDRES_DEVICE, 7'h47: 7-bit target slave address.
- QUARTER, 4: clk cycles per quarter SCL period, so one SCL period = 4*QUARTER clk.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- scl  inout  1  I2C clock; master-only, push-pull, no clock stretching.
- sda  inout  1  I2C data, open-drain: drives 0 or releases to Z. A sampled value other than 0 counts as 1; the bench supplies a pull-up.
- start_transaction  in  1  one-cycle start request; ignored while busy.
- rw  in  1  direction, 1 = read, 0 = write; sampled with start_transaction.
- i2c_prepare  out  1  one-cycle pulse requesting the next write byte on data_in.
- data_in  in  I2C_DATA_WIDTH  write byte.
- data_out  out  DATA_WIDTH  assembled read word.
- busy  out  1  high from start acceptance until the STOP completes.
- ack_err  out  1  high if the slave NACKed; cleared on the next accepted start.

Behaviour:
- Reset values:
  - Outputs: scl=1, sda=Z, i2c_prepare=0, busy=0, ack_err=0, data_out=0.
  - Internals: state=IDLE, all counters 0.
- Reset mid-transaction is abortive: lines are released in the same cycle and no STOP is generated.
- Bit timing, per bit in quarters Q0..Q3:
  - Q0: SCL low; SDA changes at Q0 start.
  - Q1: SCL low.
  - Q2, Q3: SCL high; SDA sampled at the end of Q2.
- START: SDA falls while SCL high, held one half period, then SCL falls.
- STOP: SDA low with SCL low; SCL rises; SDA released one half period later.
- Address byte = {ADDRES_DEVICE, rw}, MSB first: 0x8E for write, 0x8F for read with the default address.
- State machine:
  - IDLE → START when start_transaction && !busy. busy rises the next cycle, rw is latched and ack_err cleared.
  - START → ADDR → ADDR_ACK (master releases SDA and samples).
  - ADDR_ACK: NACK → STOP with ack_err=1. ACK → WR_BYTE (write) or RD_BYTE (read).
  - WR_BYTE → WR_ACK. In WR_ACK, NACK → STOP with ack_err=1; ACK on the last byte → STOP; otherwise → WR_BYTE.
  - RD_BYTE: master releases SDA and shifts in 8 bits, MSB first.
  - RD_ACK: master drives ACK(0) for bytes 1..BYTES-1 and NACK(release) after the last byte, then → STOP.
  - STOP → IDLE, with busy falling the cycle after SDA is released.
- i2c_prepare (write only):
  - Pulses once at Q0 entry of ADDR_ACK, requesting byte 1.
  - Pulses at Q0 of each WR_ACK except the last, requesting the next byte.
  - data_in is latched at Q0 start of the following byte's MSB, i.e. ≥2*QUARTER clk after the pulse, so a host answering within 2 clk is always in time.
- Read data:
  - Each received byte is shifted into the byte counter's slot, MSB byte first.
  - data_out updates only when the last byte completes and holds until the next read completes.
- A start_transaction pulse while busy is dropped and not queued.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP).
  - R/W bit constants READ=1, WRITE=0.
  - Quarter-index constants; also shared by the slave driver.
- One sub-module: i2c_scl_tick, a QUARTER divider emitting a quarter strobe and a 2-bit quarter index. Everything else stays in the FSM.

Test Plan:
- Write 0xA1A2A3A4 to slave 0x47: pulse start (rw=0); host answers each i2c_prepare 2 clk later with A1, A2, A3, A4 → bus shows START, 0x8E, ACK, A1/ACK, A2/ACK, A3/ACK, A4/ACK, STOP; exactly 4 prepare pulses; slave receives 0xA1A2A3A4; busy drops in <1000 clk; ack_err=0.
- Read from slave 0x47 supplying C1..C4: start with rw=1 → bus shows 0x8F, ACK, then C1 ACK, C2 ACK, C3 ACK, C4 NACK, STOP; data_out=0xC1C2C3C4; no i2c_prepare pulses.
- Slave address set to 0x48: write start → address NACK → STOP immediately; ack_err=1, no data bytes, busy drops; next start clears ack_err.
- start_transaction pulsed again mid-write → ignored; byte sequence and final word unchanged.
- rst asserted during byte 2 of a write → next cycle scl=1, sda=Z, busy=0; a fresh write then completes normally.
- Protocol checker throughout: SDA never changes while SCL is high except at START/STOP; SCL high/low phases each last 2*QUARTER clk.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master FSM states, R/W bit encoding and the
// quarter-period indices used by both the master and the slave driver.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        ADDR     = 4'd2,
        ADDR_ACK = 4'd3,
        WR_BYTE  = 4'd4,
        WR_ACK   = 4'd5,
        RD_BYTE  = 4'd6,
        RD_ACK   = 4'd7,
        STOP     = 4'd8
    } state_t;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Q0/Q1 hold SCL low, Q2/Q3 hold it high.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_scl_tick.sv
// Quarter-period divider: strobe marks the last clk of each quarter and
// quarter counts Q0..Q3; both are held at zero while not running.
module i2c_scl_tick
    import i2c_pkg::*;
#(
    parameter int QUARTER = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       strobe,
    output logic [1:0] quarter
);

    localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

    logic [CW-1:0] cnt;

    assign strobe = run && (cnt == CW'(QUARTER - 1));

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt     <= '0;
            quarter <= Q0;
        end else if (strobe) begin
            cnt     <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master_driver.sv
// Single-master I2C driver: one DATA_WIDTH word per transaction to/from a
// fixed 7-bit slave, MSB byte first, push-pull SCL and open-drain SDA.
module i2c_master_driver
    import i2c_pkg::*;
#(
    parameter int         I2C_DATA_WIDTH = 8,
    parameter int         DATA_WIDTH     = 32,
    parameter logic [6:0] ADDRES_DEVICE  = 7'h47,
    parameter int         QUARTER        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    inout  wire                       scl,
    inout  wire                       sda,
    input  logic                      start_transaction,
    input  logic                      rw,
    output logic                      i2c_prepare,
    input  logic [I2C_DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      busy,
    output logic                      ack_err
);

    localparam int BYTES = DATA_WIDTH / I2C_DATA_WIDTH;
    localparam int BW    = $clog2(I2C_DATA_WIDTH);
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int MSB   = I2C_DATA_WIDTH - 1;

    localparam logic [BW-1:0]  LAST_BIT  = BW'(I2C_DATA_WIDTH - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

    state_t                    state;
    logic                      rw_q;
    logic                      sda_low;
    logic                      sda_smp;
    logic [BW-1:0]             bit_cnt;
    logic [BCW-1:0]            byte_cnt;
    logic [I2C_DATA_WIDTH-1:0] tx_shift;
    logic [I2C_DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0]     rd_word;

    logic       run;
    logic       strobe;
    logic [1:0] quarter;
    logic       sample_pt;
    logic       bit_end;
    logic       sda_in;
    logic       accept;

    function automatic logic [DATA_WIDTH-1:0] put_byte(
        input logic [DATA_WIDTH-1:0]     word,
        input logic [BCW-1:0]            idx,
        input logic [I2C_DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        r = word;
        for (int i = 0; i < BYTES; i++) begin
            if (idx == BCW'(i)) r[(BYTES-1-i)*I2C_DATA_WIDTH +: I2C_DATA_WIDTH] = b;
        end
        return r;
    endfunction

    assign run = (state != IDLE);

    i2c_scl_tick #(.QUARTER(QUARTER)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .strobe  (strobe),
        .quarter (quarter)
    );

    assign sample_pt = strobe && (quarter == Q2);
    assign bit_end   = strobe && (quarter == Q3);
    assign sda_in    = (sda != 1'b0);
    assign accept    = (state == IDLE) && start_transaction && !busy;

    // SCL idles high through START; every other state follows the quarter phase.
    assign scl = ((state == IDLE) || (state == START)) ? 1'b1 : quarter[1];
    assign sda = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            ack_err     <= 1'b0;
            i2c_prepare <= 1'b0;
            sda_low     <= 1'b0;
            rw_q        <= WRITE;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            data_out    <= '0;
        end else begin
            i2c_prepare <= 1'b0;
            case (state)
                IDLE: begin
                    sda_low <= 1'b0;
                    if (accept) begin
                        state    <= START;
                        busy     <= 1'b1;
                        rw_q     <= rw;
                        ack_err  <= 1'b0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                START: begin
                    if (strobe && (quarter == Q1)) sda_low <= 1'b1;
                    if (bit_end) begin
                        state   <= ADDR;
                        sda_low <= ~tx_shift[MSB];
                    end
                end
                ADDR, WR_BYTE: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt     <= '0;
                            sda_low     <= 1'b0;
                            state       <= (state == ADDR) ? ADDR_ACK : WR_ACK;
                            // Request the next write byte a full ACK bit ahead of its use.
                            i2c_prepare <= (state == ADDR) ? (rw_q == WRITE) : (byte_cnt != LAST_BYTE);
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            sda_low <= ~tx_shift[MSB];
                        end
                    end
                end
                ADDR_ACK: begin
                    if (bit_end) begin
                        if (sda_smp) begin
                            state   <= STOP;
                            ack_err <= 1'b1;
                            sda_low <= 1'b1;
                        end else if (rw_q == READ) begin
                            state   <= RD_BYTE;
                            sda_low <= 1'b0;
                        end else begin
                            state   <= WR_BYTE;
                            sda_low <= ~data_in[MSB];
                        end
                    end
                end
                WR_ACK: begin
                    if (bit_end) begin
                        if (sda_smp) begin
                            state   <= STOP;
                            ack_err <= 1'b1;
                            sda_low <= 1'b1;
                        end else if (byte_cnt == LAST_BYTE) begin
                            state   <= STOP;
                            sda_low <= 1'b1;
                        end else begin
                            state    <= WR_BYTE;
                            byte_cnt <= byte_cnt + BCW'(1);
                            sda_low  <= ~data_in[MSB];
                        end
                    end
                end
                RD_BYTE: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= RD_ACK;
                            // ACK every byte but the last, which is NACKed by releasing SDA.
                            sda_low <= (byte_cnt != LAST_BYTE);
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                RD_ACK: begin
                    if (bit_end) begin
                        if (byte_cnt == LAST_BYTE) begin
                            state    <= STOP;
                            sda_low  <= 1'b1;
                            data_out <= rd_word;
                        end else begin
                            state    <= RD_BYTE;
                            byte_cnt <= byte_cnt + BCW'(1);
                            sda_low  <= 1'b0;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state   <= IDLE;
                        sda_low <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sample_pt) sda_smp <= sda_in;

        if (accept) begin
            tx_shift <= {ADDRES_DEVICE, rw};
        end else if (bit_end && ((state == START) ||
                                 (((state == ADDR) || (state == WR_BYTE)) && (bit_cnt != LAST_BIT)))) begin
            tx_shift <= tx_shift << 1;
        end else if (bit_end && (((state == ADDR_ACK) && (rw_q == WRITE)) || (state == WR_ACK))) begin
            tx_shift <= data_in << 1;
        end

        if (sample_pt && (state == RD_BYTE)) rx_shift <= {rx_shift[I2C_DATA_WIDTH-2:0], sda_in};
        if (bit_end && (state == RD_BYTE) && (bit_cnt == LAST_BIT))
            rd_word <= put_byte(rd_word, byte_cnt, rx_shift);
    end

endmodule

// File: tb/tb_i2c_master_driver.sv
// Directed bench for i2c_master_driver: a slave model decodes the bus, answers
// ACK/data, checks START/STOP and SCL phase timing, and a host answers i2c_prepare.
module tb_i2c_master_driver;

    localparam int QUARTER = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_transaction = 1'b0;
    logic        rw = 1'b0;
    logic        i2c_prepare;
    logic [7:0]  data_in = 8'h00;
    logic [31:0] data_out;
    logic        busy;
    logic        ack_err;
    wire         scl;
    wire         sda;

    int checks = 0;
    int errors = 0;

    i2c_master_driver #(
        .I2C_DATA_WIDTH (8),
        .DATA_WIDTH     (32),
        .ADDRES_DEVICE  (7'h47),
        .QUARTER        (QUARTER)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .scl               (scl),
        .sda               (sda),
        .start_transaction (start_transaction),
        .rw                (rw),
        .i2c_prepare       (i2c_prepare),
        .data_in           (data_in),
        .data_out          (data_out),
        .busy              (busy),
        .ack_err           (ack_err)
    );

    always #5 clk = ~clk;

    pullup (sda);

    logic slv_rel = 1'b1;
    assign sda = slv_rel ? 1'bz : 1'b0;

    // Slave model / bus monitor state
    logic [6:0]  slv_addr = 7'h47;
    logic [31:0] slv_rd_word = 32'h0;
    logic [7:0]  log_byte [16];
    logic        log_ack  [16];
    int          n_log = 0, n_start = 0, n_stop = 0, prep_cnt = 0;
    int          bitn = 0, byten = 0, ph_cnt = 0;
    logic [7:0]  shift = 8'h0, cur_byte = 8'h0;
    logic        ackbit = 1'b1, s_rw = 1'b0, addr_ok = 1'b0, slv_tx = 1'b0;
    logic        first = 1'b0, risen = 1'b0, in_frame = 1'b0;
    logic        p_scl = 1'b1, p_sda = 1'b1, cur_scl, cur_sda;

    // Host write-data table
    logic [7:0] wr_bytes [4];
    int         host_idx = 0;

    always @(negedge clk) begin
        cur_scl = (scl === 1'b1);
        cur_sda = (sda !== 1'b0);
        if (i2c_prepare === 1'b1) prep_cnt++;
        if (rst) begin
            in_frame = 1'b0; first = 1'b0; risen = 1'b0; slv_rel = 1'b1; slv_tx = 1'b0; ph_cnt = 0;
        end else begin
            ph_cnt++;
            if (p_scl && cur_scl && (p_sda != cur_sda)) begin
                if (!cur_sda) begin
                    n_start++;
                    checks++;
                    if (in_frame) begin
                        errors++;
                        $display("FAIL sda_while_scl_high: got START inside frame, expected no SDA change");
                    end
                    in_frame = 1'b1; first = 1'b1; risen = 1'b0; bitn = 0; byten = 0; shift = 8'h0;
                end else begin
                    n_stop++;
                    checks++;
                    if (!in_frame) begin
                        errors++;
                        $display("FAIL sda_while_scl_high: got STOP outside frame, expected no SDA change");
                    end
                    in_frame = 1'b0; risen = 1'b0;
                end
            end
            if (in_frame && !p_scl && cur_scl) begin
                checks++;
                if (ph_cnt != 2*QUARTER) begin
                    errors++;
                    $display("FAIL scl_low_phase: got %0d clk, expected %0d", ph_cnt, 2*QUARTER);
                end
                ph_cnt = 0; risen = 1'b1;
                if (bitn < 8) shift = {shift[6:0], cur_sda};
                else ackbit = cur_sda;
            end
            if (in_frame && p_scl && !cur_scl) begin
                if (risen) begin
                    checks++;
                    if (ph_cnt != 2*QUARTER) begin
                        errors++;
                        $display("FAIL scl_high_phase: got %0d clk, expected %0d", ph_cnt, 2*QUARTER);
                    end
                end
                ph_cnt = 0;
                if (first) begin
                    first = 1'b0;
                    slv_rel = 1'b1;
                end else if (bitn < 7) begin
                    bitn++;
                    slv_rel = slv_tx ? slv_rd_word[31 - 8*(byten-1) - bitn] : 1'b1;
                end else if (bitn == 7) begin
                    bitn = 8;
                    cur_byte = shift;
                    if (byten == 0) begin
                        s_rw = shift[0];
                        addr_ok = (shift[7:1] == slv_addr);
                        slv_rel = !addr_ok;
                    end else begin
                        slv_rel = s_rw;
                    end
                end else begin
                    if (n_log < 16) begin
                        log_byte[n_log] = cur_byte;
                        log_ack[n_log]  = ackbit;
                        n_log++;
                    end
                    bitn = 0;
                    byten++;
                    slv_tx = s_rw && addr_ok && !ackbit && (byten <= 4);
                    slv_rel = slv_tx ? slv_rd_word[31 - 8*(byten-1)] : 1'b1;
                end
            end
        end
        p_scl = cur_scl;
        p_sda = cur_sda;
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (i2c_prepare === 1'b1) begin
                repeat (2) @(posedge clk);
                #1;
                data_in = wr_bytes[host_idx % 4];
                host_idx++;
            end
        end
    end

    task automatic clear_log();
        n_log = 0; n_start = 0; n_stop = 0; prep_cnt = 0; host_idx = 0;
        for (int i = 0; i < 16; i++) begin
            log_byte[i] = 8'h00;
            log_ack[i]  = 1'b0;
        end
    endtask

    task automatic pulse_start(input logic dir);
        start_transaction = 1'b1;
        rw = dir;
        @(posedge clk); #1;
        start_transaction = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_log(input string name, input int n, input logic [7:0] eb [5], input logic ea [5]);
        checks++;
        if (n_log != n) begin
            errors++;
            $display("FAIL %s_nbytes: got %0d, expected %0d", name, n_log, n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (log_byte[i] !== eb[i] || log_ack[i] !== ea[i]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %02h ack %0b, expected %02h ack %0b",
                         name, i, log_byte[i], log_ack[i], eb[i], ea[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (scl !== 1'b1)      begin errors++; $display("FAIL reset_scl: got %b, expected 1", scl); end
        checks++; if (sda !== 1'b1)      begin errors++; $display("FAIL reset_sda: got %b, expected released(1)", sda); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (ack_err !== 1'b0)  begin errors++; $display("FAIL reset_ack_err: got %b, expected 0", ack_err); end
        checks++; if (i2c_prepare !== 1'b0) begin errors++; $display("FAIL reset_prepare: got %b, expected 0", i2c_prepare); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %08h, expected 00000000", data_out); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input string name, input logic [31:0] word);
        logic [7:0] eb [5];
        logic       ea [5];
        int         cyc;
        wr_bytes = '{word[31:24], word[23:16], word[15:8], word[7:0]};
        eb = '{8'h8E, word[31:24], word[23:16], word[15:8], word[7:0]};
        ea = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        clear_log();
        pulse_start(1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_rise: got %b, expected 1", name, busy); end
        wait_idle(cyc);
        checks++; if (cyc >= 1000) begin errors++; $display("FAIL %s_duration: got %0d clk, expected < 1000", name, cyc); end
        check_log(name, 5, eb, ea);
        checks++; if (prep_cnt != 4) begin errors++; $display("FAIL %s_prepare_count: got %0d, expected 4", name, prep_cnt); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL %s_ack_err: got %b, expected 0", name, ack_err); end
        checks++;
        if (n_start != 1 || n_stop != 1) begin
            errors++;
            $display("FAIL %s_start_stop: got %0d/%0d, expected 1/1", name, n_start, n_stop);
        end
        checks++;
        if ({log_byte[1], log_byte[2], log_byte[3], log_byte[4]} !== word) begin
            errors++;
            $display("FAIL %s_slave_word: got %08h, expected %08h", name,
                     {log_byte[1], log_byte[2], log_byte[3], log_byte[4]}, word);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        do_write("write", 32'hA1A2A3A4);
    endtask

    task automatic test_read();
        logic [7:0] eb [5];
        logic       ea [5];
        int         cyc;
        slv_rd_word = 32'hC1C2C3C4;
        eb = '{8'h8F, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        ea = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        clear_log();
        pulse_start(1'b1);
        wait_idle(cyc);
        checks++; if (cyc >= 1000) begin errors++; $display("FAIL read_duration: got %0d clk, expected < 1000", cyc); end
        check_log("read", 5, eb, ea);
        checks++; if (data_out !== 32'hC1C2C3C4) begin errors++; $display("FAIL read_data_out: got %08h, expected c1c2c3c4", data_out); end
        checks++; if (prep_cnt != 0) begin errors++; $display("FAIL read_prepare_count: got %0d, expected 0", prep_cnt); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL read_ack_err: got %b, expected 0", ack_err); end
        checks++; if (n_stop != 1) begin errors++; $display("FAIL read_stop: got %0d, expected 1", n_stop); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_addr_nack();
        logic [7:0] eb [5];
        logic       ea [5];
        int         cyc;
        eb = '{8'h8E, 8'h00, 8'h00, 8'h00, 8'h00};
        ea = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        slv_addr = 7'h48;
        clear_log();
        pulse_start(1'b0);
        wait_idle(cyc);
        checks++; if (cyc >= 1000) begin errors++; $display("FAIL nack_busy_drop: got %0d clk, expected < 1000", cyc); end
        check_log("nack", 1, eb, ea);
        checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL nack_ack_err: got %b, expected 1", ack_err); end
        checks++; if (n_stop != 1) begin errors++; $display("FAIL nack_stop: got %0d, expected 1", n_stop); end
        repeat (3) @(posedge clk);
        #1;
        slv_addr = 7'h47;
        wr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_log();
        pulse_start(1'b0);
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL nack_clear_on_start: got %b, expected 0", ack_err); end
        wait_idle(cyc);
        checks++; if (n_log != 5 || ack_err !== 1'b0) begin
            errors++; $display("FAIL nack_recovery: got %0d bytes ack_err %b, expected 5 bytes ack_err 0", n_log, ack_err);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_start_while_busy();
        logic [7:0] eb [5];
        logic       ea [5];
        int         cyc;
        wr_bytes = '{8'h5A, 8'hA5, 8'h0F, 8'hF0};
        eb = '{8'h8E, 8'h5A, 8'hA5, 8'h0F, 8'hF0};
        ea = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        clear_log();
        pulse_start(1'b0);
        repeat (200) @(posedge clk);
        #1;
        pulse_start(1'b1);
        wait_idle(cyc);
        check_log("busy_start", 5, eb, ea);
        checks++; if (n_start != 1) begin errors++; $display("FAIL busy_start_count: got %0d, expected 1", n_start); end
        checks++; if (prep_cnt != 4) begin errors++; $display("FAIL busy_start_prepare: got %0d, expected 4", prep_cnt); end
        repeat (50) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_queued: got busy %b, expected 0", busy); end
        checks++; if (data_out !== 32'hC1C2C3C4) begin errors++; $display("FAIL data_out_hold: got %08h, expected c1c2c3c4", data_out); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        wr_bytes = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        clear_log();
        pulse_start(1'b0);
        cyc = 0;
        while (n_log < 2 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (n_log != 2) begin errors++; $display("FAIL reset_mid_reach_byte2: got %0d bytes, expected 2", n_log); end
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (scl !== 1'b1)  begin errors++; $display("FAIL reset_mid_scl: got %b, expected 1", scl); end
        checks++; if (sda !== 1'b1)  begin errors++; $display("FAIL reset_mid_sda: got %b, expected released(1)", sda); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b, expected 0", busy); end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        do_write("after_reset", 32'h3CFF0081);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_start_while_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
